int_res_mem_ctrl: RTL and testbench

INT_RES_MEM_CTRL -- requirements
Module: int_res_mem_ctrl

---
 rtl/int_res_mem_ctrl_pkg.sv | 26 ++
 rtl/int_res_addr_decode.sv | 24 ++
 rtl/int_res_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_int_res_mem_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_res_mem_ctrl_pkg.sv
// Shared definitions for the intermediate-result memory: bank geometry,
// address/data types, the data-width selector and a sign-extension helper.
package int_res_mem_ctrl_pkg;

  localparam int CIM_INT_RES_NUM_BANKS          = 4;
  localparam int CIM_INT_RES_BANK_SIZE_NUM_WORD = 14336;
  localparam int INT_RES_TOTAL_WORDS = CIM_INT_RES_NUM_BANKS * CIM_INT_RES_BANK_SIZE_NUM_WORD;
  localparam int BANK_IDX_W          = $clog2(CIM_INT_RES_NUM_BANKS);

  typedef logic [15:0]           IntResAddr_t;
  typedef logic [13:0]           IntResBankAddr_t;
  typedef logic [14:0]           IntResSingle_t;
  typedef logic [29:0]           IntResDouble_t;
  typedef logic [BANK_IDX_W-1:0] BankIdx_t;

  typedef enum logic {
    SINGLE_WIDTH = 1'b0,
    DOUBLE_WIDTH = 1'b1
  } DataWidth_t;

  // Widen a single 15-bit word to the 30-bit result, preserving its sign.
  function automatic IntResDouble_t sign_extend(input IntResSingle_t w);
    return {{15{w[14]}}, w};
  endfunction

endpackage

// File: rtl/int_res_addr_decode.sv
// Splits a flat word address into a bank index and an in-bank offset.
// The input is one bit wider than IntResAddr_t so that A+1 never wraps.
module int_res_addr_decode
  import int_res_mem_ctrl_pkg::*;
(
  input  logic [16:0]     word_addr,
  output BankIdx_t        bank,
  output IntResBankAddr_t offset
);

  // Range-compare against each bank window; bank size is not a power of two.
  always_comb begin
    bank   = '0;
    offset = '0;
    for (int b = 0; b < CIM_INT_RES_NUM_BANKS; b++) begin
      if (int'(word_addr) >= b * CIM_INT_RES_BANK_SIZE_NUM_WORD &&
          int'(word_addr) < (b + 1) * CIM_INT_RES_BANK_SIZE_NUM_WORD) begin
        bank   = BankIdx_t'(b);
        offset = IntResBankAddr_t'(int'(word_addr) - b * CIM_INT_RES_BANK_SIZE_NUM_WORD);
      end
    end
  end

endmodule

// File: rtl/int_res_mem_ctrl.sv
// Round-robin controller that lets NUM_REQ requesters share the banked
// intermediate-result memory with single (15-bit) or double (30-bit) accesses.
module int_res_mem_ctrl
  import int_res_mem_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  IntResAddr_t                      req_addr  [NUM_REQ],
  input  DataWidth_t                       req_width [NUM_REQ],
  input  logic [NUM_REQ-1:0]               req_we,
  input  IntResDouble_t                    req_wdata [NUM_REQ],
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output IntResDouble_t                    rdata,
  output logic                             addr_err,
  output logic [CIM_INT_RES_NUM_BANKS-1:0] bank_en,
  output logic                             bank_we,
  output IntResBankAddr_t                  bank_addr,
  output IntResSingle_t                    bank_wdata,
  input  IntResSingle_t                    bank_rdata [CIM_INT_RES_NUM_BANKS],
  output logic                             busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, WORD0, WORD1, RESP} state_t;

  state_t          state, state_next;
  logic [IDX_W-1:0] last_reg, win_reg, pick;
  logic            found;
  int              cand;
  IntResAddr_t     addr_reg;
  DataWidth_t      width_reg;
  logic            we_reg;
  IntResDouble_t   wdata_reg;
  BankIdx_t        prev_bank_reg;
  IntResSingle_t   hi_reg;
  logic [16:0]     cur_addr;
  BankIdx_t        cur_bank;
  IntResBankAddr_t cur_off;
  logic            is_double;
  logic            range_err;

  assign is_double = (width_reg == DOUBLE_WIDTH);
  assign range_err = ({1'b0, addr_reg} + 17'(is_double)) >= 17'(INT_RES_TOTAL_WORDS);
  assign cur_addr  = {1'b0, addr_reg} + ((state == WORD1) ? 17'd1 : 17'd0);
  assign busy      = (state != IDLE);

  int_res_addr_decode u_decode (
    .word_addr (cur_addr),
    .bank      (cur_bank),
    .offset    (cur_off)
  );

  // Round-robin pick: scan upward starting just after the last grant.
  always_comb begin
    found = 1'b0;
    pick  = last_reg;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_reg) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Latch the winner's payload, track arbitration and the upper read word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_reg      <= IDX_W'(NUM_REQ - 1);
      win_reg       <= '0;
      addr_reg      <= '0;
      width_reg     <= SINGLE_WIDTH;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      prev_bank_reg <= '0;
      hi_reg        <= '0;
    end else begin
      if (state == IDLE && found) begin
        last_reg  <= pick;
        win_reg   <= pick;
        addr_reg  <= req_addr[pick];
        width_reg <= req_width[pick];
        we_reg    <= req_we[pick];
        wdata_reg <= req_wdata[pick];
      end
      // Bank read data arrives one cycle late, so remember which bank was read.
      prev_bank_reg <= cur_bank;
      if (state == WORD1) hi_reg <= bank_rdata[prev_bank_reg];
    end
  end

  // Next-state and all control outputs; every output idles at zero.
  always_comb begin
    state_next = state;
    gnt        = '0;
    rvalid     = '0;
    addr_err   = 1'b0;
    bank_en    = '0;
    bank_we    = 1'b0;
    bank_addr  = '0;
    bank_wdata = '0;
    rdata      = '0;
    case (state)
      IDLE: begin
        if (found) state_next = WORD0;
      end
      WORD0: begin
        gnt[win_reg] = 1'b1;
        if (range_err) begin
          addr_err   = 1'b1;
          state_next = IDLE;
        end else begin
          bank_en[cur_bank] = 1'b1;
          bank_we           = we_reg;
          bank_addr         = cur_off;
          bank_wdata        = is_double ? wdata_reg[29:15] : wdata_reg[14:0];
          if (is_double)   state_next = WORD1;
          else if (we_reg) state_next = IDLE;
          else             state_next = RESP;
        end
      end
      WORD1: begin
        bank_en[cur_bank] = 1'b1;
        bank_we           = we_reg;
        bank_addr         = cur_off;
        bank_wdata        = wdata_reg[14:0];
        state_next        = we_reg ? IDLE : RESP;
      end
      RESP: begin
        rvalid[win_reg] = 1'b1;
        rdata = is_double ? {hi_reg, bank_rdata[prev_bank_reg]}
                          : sign_extend(bank_rdata[prev_bank_reg]);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_res_mem_ctrl.sv
// Bench for int_res_mem_ctrl: bank memory model, directed vector table,
// randomized accesses against a flat-memory reference, reset and arbitration sequences.
module tb_int_res_mem_ctrl;
  import int_res_mem_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req;
  IntResAddr_t   req_addr  [2];
  DataWidth_t    req_width [2];
  logic [1:0]    req_we;
  IntResDouble_t req_wdata [2];
  logic [1:0]    gnt, rvalid;
  IntResDouble_t rdata;
  logic          addr_err;
  logic [3:0]    bank_en;
  logic          bank_we;
  IntResBankAddr_t bank_addr;
  IntResSingle_t bank_wdata;
  IntResSingle_t bank_rdata [4] = '{default: '0};
  logic          busy;

  logic [14:0] bmem    [4][14336] = '{default: '{default: '0}};
  logic [14:0] ref_mem [57344]    = '{default: '0};

  int pass_cnt   = 0;
  int chk_cnt    = 0;
  int excl_viol  = 0;

  always #5 clk = ~clk;

  int_res_mem_ctrl #(.NUM_REQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_width(req_width),
    .req_we(req_we), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .addr_err(addr_err), .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .busy(busy)
  );

  // Bank memories: synchronous write, registered read.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_en[b]) begin
        if (bank_we) bmem[b][bank_addr] <= bank_wdata;
        else         bank_rdata[b]      <= bmem[b][bank_addr];
      end
    end
  end

  // At most one gnt and one rvalid bit per cycle.
  always @(negedge clk) begin
    if (!rst && ($countones(gnt) > 1 || $countones(rvalid) > 1)) excl_viol++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference memory update from the access rules (flat word array).
  task automatic model_apply(input int addr, input bit dw, input bit we, input logic [29:0] wd);
    int v;
    v = int'(wd);
    if (we && (addr + (dw ? 1 : 0)) < 57344) begin
      if (dw) begin
        ref_mem[addr]     = 15'(v / 32768);
        ref_mem[addr + 1] = 15'(v % 32768);
      end else begin
        ref_mem[addr] = 15'(v % 32768);
      end
    end
  endtask

  // Issue one access from requester r and compare everything observed against expectations.
  task automatic verify(input string tag, input int r, input int addr, input bit dw, input bit we,
                        input logic [29:0] wd, input bit e_err, input logic [3:0] e_ben,
                        input int e_baddr, input int e_lat, input logic [29:0] e_rd);
    bit got;
    logic a_err, a_bwe;
    logic [3:0] a_ben;
    int a_baddr, a_lat;
    logic [29:0] a_rd;
    got = 0; a_err = 0; a_bwe = 0; a_ben = 0; a_baddr = 0; a_lat = -1; a_rd = 0;
    @(negedge clk);
    req_addr[r]  = IntResAddr_t'(addr);
    req_width[r] = dw ? DOUBLE_WIDTH : SINGLE_WIDTH;
    req_we[r]    = we;
    req_wdata[r] = wd;
    req[r]       = 1'b1;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (gnt[r]) begin
        got = 1; a_err = addr_err; a_ben = bank_en; a_baddr = int'(bank_addr); a_bwe = bank_we;
      end
    end
    req[r] = 1'b0;
    chk({tag, "_gnt"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, "_err"}, 64'(a_err), 64'(e_err));
      chk({tag, "_ben"}, 64'(a_ben), 64'(e_ben));
      if (e_ben != 0) chk({tag, "_baddr"}, 64'(a_baddr), 64'(e_baddr));
      if (!e_err) chk({tag, "_bwe"}, 64'(a_bwe), 64'(we));
      for (int n = 1; n <= 4; n++) begin
        @(negedge clk);
        if (rvalid != 0 && a_lat == -1) begin
          a_lat = rvalid[r] ? n : -2;
          a_rd  = rdata;
        end
      end
      chk({tag, "_lat"}, 64'(a_lat), 64'(e_lat));
      if (e_lat > 0) chk({tag, "_rdata"}, 64'(a_rd), 64'(e_rd));
    end
    $display("txn %s: r=%0d addr=%0d dw=%0d we=%0d wd=0x%0h err=%0d ben=%b lat=%0d rdata=0x%0h",
             tag, r, addr, dw, we, wd, a_err, a_ben, a_lat, a_rd);
  endtask

  typedef struct {
    int          r;
    int          addr;
    bit          dw;
    bit          we;
    logic [29:0] wd;
    bit          e_err;
    logic [3:0]  e_ben;
    int          e_baddr;
    int          e_lat;
    logic [29:0] e_rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int sel, addr, r, e_lat, e_baddr, v;
    bit dw, we, e_err;
    logic [29:0] wd, e_rd;
    logic [3:0] e_ben;
    int gidx [4];
    int ng;
    int rv_seen;

    req = '0; req_we = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_width[i] = SINGLE_WIDTH; req_wdata[i] = '0;
    end

    vecs[0]  = '{0, 100,   0, 1, 30'h1234,     0, 4'b0001, 100,   -1, 30'h0};
    vecs[1]  = '{0, 100,   0, 0, 30'h0,        0, 4'b0001, 100,    1, 30'h00001234};
    vecs[2]  = '{1, 20000, 0, 1, 30'h4000,     0, 4'b0010, 5664,  -1, 30'h0};
    vecs[3]  = '{1, 20000, 0, 0, 30'h0,        0, 4'b0010, 5664,   1, 30'h3FFFC000};
    vecs[4]  = '{0, 14335, 1, 1, 30'h2ABCD123, 0, 4'b0001, 14335, -1, 30'h0};
    vecs[5]  = '{1, 14335, 1, 0, 30'h0,        0, 4'b0001, 14335,  2, 30'h2ABCD123};
    vecs[6]  = '{0, 57343, 1, 0, 30'h0,        1, 4'b0000, 0,     -1, 30'h0};
    vecs[7]  = '{0, 57343, 0, 0, 30'h0,        0, 4'b1000, 14335,  1, 30'h0};
    vecs[8]  = '{1, 57344, 0, 1, 30'h1,        1, 4'b0000, 0,     -1, 30'h0};
    vecs[9]  = '{0, 43007, 1, 1, 30'h12345678, 0, 4'b0100, 14335, -1, 30'h0};
    vecs[10] = '{1, 43007, 1, 0, 30'h0,        0, 4'b0100, 14335,  2, 30'h12345678};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({gnt, rvalid, addr_err, bank_en, bank_we, busy}), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      verify($sformatf("vec%0d", i), vecs[i].r, vecs[i].addr, vecs[i].dw, vecs[i].we, vecs[i].wd,
             vecs[i].e_err, vecs[i].e_ben, vecs[i].e_baddr, vecs[i].e_lat, vecs[i].e_rd);
      model_apply(vecs[i].addr, vecs[i].dw, vecs[i].we, vecs[i].wd);
    end
    chk("straddle_bank0_14335", 64'(bmem[0][14335]), 64'h5579);
    chk("straddle_bank1_0", 64'(bmem[1][0]), 64'h5123);

    // Randomized accesses against the flat reference memory.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       addr = int'($urandom_range(0, 65535));
        1:       addr = 14330 + int'($urandom_range(0, 11));
        2:       addr = 57338 + int'($urandom_range(0, 9));
        default: addr = 100 + int'($urandom_range(0, 7));
      endcase
      r  = int'($urandom_range(0, 1));
      dw = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      wd = 30'($urandom);
      e_err   = (addr + (dw ? 1 : 0)) >= 57344;
      e_ben   = e_err ? 4'b0000 : 4'(1 << (addr / 14336));
      e_baddr = addr % 14336;
      e_lat   = (we || e_err) ? -1 : (dw ? 2 : 1);
      e_rd    = '0;
      if (!e_err && !we) begin
        if (dw) begin
          e_rd = 30'(int'(ref_mem[addr]) * 32768 + int'(ref_mem[addr + 1]));
        end else begin
          v = int'(ref_mem[addr]);
          e_rd = (v >= 16384) ? 30'((1 << 30) - 32768 + v) : 30'(v);
        end
      end
      verify($sformatf("rnd%0d", i), r, addr, dw, we, wd, e_err, e_ben, e_baddr, e_lat, e_rd);
      model_apply(addr, dw, we, wd);
    end

    // Reset in WORD1 of a double read, then round-robin from index 0.
    @(negedge clk);
    req_addr[0] = 16'd200; req_width[0] = DOUBLE_WIDTH; req_we[0] = 1'b0; req[0] = 1'b1;
    ng = 0;
    for (int n = 0; n < 10 && ng == 0; n++) begin
      @(negedge clk);
      if (gnt[0]) ng = 1;
    end
    req[0] = 1'b0;
    chk("rst_seq_gnt", 64'(ng), 64'd1);
    @(negedge clk);
    chk("rst_seq_word1_ben", 64'(bank_en), 64'b0001);
    rst = 1'b1;
    #1;
    chk("rst_async_ctrl", 64'({gnt, rvalid, addr_err, bank_en, bank_we, busy}), 64'd0);
    chk("rst_async_bank", 64'({bank_addr, bank_wdata}), 64'd0);
    chk("rst_async_rdata", 64'(rdata), 64'd0);
    rv_seen = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      if (rvalid != 0) rv_seen++;
    end
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (rvalid != 0) rv_seen++;
    end
    chk("rst_no_rvalid", 64'(rv_seen), 64'd0);

    for (int i = 0; i < 2; i++) begin
      req_addr[i] = 16'd100; req_width[i] = SINGLE_WIDTH; req_we[i] = 1'b0;
    end
    req = 2'b11;
    ng = 0;
    for (int k = 0; k < 4; k++) gidx[k] = -1;
    for (int n = 0; n < 60 && ng < 4; n++) begin
      @(negedge clk);
      if (gnt != 0) begin
        gidx[ng] = gnt[1] ? 1 : 0;
        $display("txn rr%0d: granted %0d", ng, gidx[ng]);
        ng++;
      end
    end
    req = '0;
    chk("rr_count", 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_order%0d", k), 64'(gidx[k]), 64'(k % 2));
    repeat (4) @(negedge clk);
    chk("mutual_exclusion", 64'(excl_viol), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
